// File: rtl/vga_pkg.sv
// Shared VGA geometry for 800x600 @ 60 Hz (40 MHz pixel clock).
// Sync end positions are derived where they are used, not stored here.
package vga_pkg;

    localparam logic [10:0] HOR_PIXELS      = 11'd800;
    localparam logic [10:0] VER_PIXELS      = 11'd600;

    localparam logic [10:0] HOR_TOTAL_TIME  = 11'd1056;
    localparam logic [10:0] HOR_BLANK_START = HOR_PIXELS;
    localparam logic [10:0] HOR_SYNC_START  = 11'd840;
    localparam logic [10:0] HOR_SYNC_TIME   = 11'd128;

    localparam logic [10:0] VER_TOTAL_TIME  = 11'd628;
    localparam logic [10:0] VER_BLANK_START = VER_PIXELS;
    localparam logic [10:0] VER_SYNC_START  = 11'd601;
    localparam logic [10:0] VER_SYNC_TIME   = 11'd4;

endpackage

// File: rtl/vga_tim.sv
// Timing bundle carried from the timing source into the draw pipeline.
interface vga_tim;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);

endinterface

// File: rtl/vga_timing_gen.sv
// Free-running 800x600 @ 60 Hz timing source with registered counts and flags.
// Optional start-of-frame pulse output compiled in with VGA_TIMING_SOF_EN.
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    vga_tim.out  tim_out
`ifdef VGA_TIMING_SOF_EN
    ,
    output logic sof
`endif
);

    localparam logic [10:0] HOR_SYNC_END = HOR_SYNC_START + HOR_SYNC_TIME - 11'd1;
    localparam logic [10:0] VER_SYNC_END = VER_SYNC_START + VER_SYNC_TIME - 11'd1;

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        line_end;
    logic        frame_end;

    assign line_end  = (hcount_q == HOR_TOTAL_TIME - 11'd1);
    assign frame_end = line_end && (vcount_q == VER_TOTAL_TIME - 11'd1);

    // Flags decode the next-count values so they land on the same edge as the counts.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (en) begin
            if (line_end) begin
                hcount_d = 11'd0;
                vcount_d = frame_end ? 11'd0 : vcount_q + 11'd1;
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end
        hblnk_d = (hcount_d >= HOR_BLANK_START);
        hsync_d = (hcount_d >= HOR_SYNC_START) && (hcount_d <= HOR_SYNC_END);
        vblnk_d = (vcount_d >= VER_BLANK_START);
        vsync_d = (vcount_d >= VER_SYNC_START) && (vcount_d <= VER_SYNC_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= 11'd0;
            vcount_q <= 11'd0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
        end
    end

    assign tim_out.hcount = hcount_q;
    assign tim_out.vcount = vcount_q;
    assign tim_out.hsync  = hsync_q;
    assign tim_out.vsync  = vsync_q;
    assign tim_out.hblnk  = hblnk_q;
    assign tim_out.vblnk  = vblnk_q;

`ifdef VGA_TIMING_SOF_EN
    logic sof_q, sof_d;

    // Only a real frame wrap raises sof; the (0,0) left by reset does not.
    always_comb begin
        sof_d = en && frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sof_q <= 1'b0;
        end else begin
            sof_q <= sof_d;
        end
    end

    assign sof = sof_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen against a linear-position frame model.
module tb_vga_timing_gen;

    localparam int H_TOT = 1056;
    localparam int V_TOT = 628;
    localparam int FRAME = H_TOT * V_TOT;

    logic clk;
    logic rst;
    logic en;
`ifdef VGA_TIMING_SOF_EN
    logic sof;
`endif

    vga_tim tim_if ();

    vga_timing_gen dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .tim_out (tim_if)
`ifdef VGA_TIMING_SOF_EN
        ,
        .sof     (sof)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: linear pixel index within the frame, plus the expected sof.
    int m_p   = 0;
    bit m_sof = 1'b0;

    typedef struct {
        int   sh;
        int   sv;
        logic r;
        logic e;
        int   h;
        int   v;
        logic hb;
        logic hs;
        logic vb;
        logic vs;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        int  eh, ev;
        bit  ehb, ehs, evb, evs;
        bit  ok;
        eh  = m_p % H_TOT;
        ev  = m_p / H_TOT;
        ehb = (eh >= 800);
        ehs = (eh >= 840) && (eh < 840 + 128);
        evb = (ev >= 600);
        evs = (ev >= 601) && (ev < 601 + 4);
        ok = (int'(tim_if.hcount) == eh) && (int'(tim_if.vcount) == ev) &&
             (tim_if.hblnk == ehb) && (tim_if.hsync == ehs) &&
             (tim_if.vblnk == evb) && (tim_if.vsync == evs);
`ifdef VGA_TIMING_SOF_EN
        ok = ok && (sof == m_sof);
`endif
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got h=%0d v=%0d hb=%0b hs=%0b vb=%0b vs=%0b, expected h=%0d v=%0d hb=%0b hs=%0b vb=%0b vs=%0b",
                     name, tim_if.hcount, tim_if.vcount, tim_if.hblnk, tim_if.hsync,
                     tim_if.vblnk, tim_if.vsync, eh, ev, ehb, ehs, evb, evs);
`ifdef VGA_TIMING_SOF_EN
            $display("FAIL %s sof: got %0b, expected %0b", name, sof, m_sof);
`endif
        end
    endtask

    // Drive inputs at the falling edge, advance the model at the rising edge,
    // return at the next falling edge for sampling.
    task automatic cyc(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        if (r) begin
            m_p   = 0;
            m_sof = 1'b0;
        end else if (e) begin
            m_p   = (m_p + 1) % FRAME;
            m_sof = (m_p == 0);
        end else begin
            m_sof = 1'b0;
        end
        @(negedge clk);
    endtask

    // Jump the counters to (h,v); flags settle on the following edge.
    task automatic seek(input int h, input int v);
        force dut.hcount_q = 11'(h);
        force dut.vcount_q = 11'(v);
        #1;
        release dut.hcount_q;
        release dut.vcount_q;
        m_p   = v * H_TOT + h;
        m_sof = 1'b0;
    endtask

    initial begin
        int hs_cnt, vs_cnt, vb_cnt, first_hb, vb_seen, first_vs_h, first_vs_v;

        tbl[0]  = '{-1,  -1, 1'b1, 1'b1,    0,   0, 0, 0, 0, 0};
        tbl[1]  = '{-1,  -1, 1'b0, 1'b1,    1,   0, 0, 0, 0, 0};
        tbl[2]  = '{-1,  -1, 1'b0, 1'b0,    1,   0, 0, 0, 0, 0};
        tbl[3]  = '{-1,  -1, 1'b0, 1'b1,    2,   0, 0, 0, 0, 0};
        tbl[4]  = '{-1,  -1, 1'b0, 1'b1,    3,   0, 0, 0, 0, 0};
        tbl[5]  = '{-1,  -1, 1'b1, 1'b0,    0,   0, 0, 0, 0, 0};
        tbl[6]  = '{-1,  -1, 1'b0, 1'b1,    1,   0, 0, 0, 0, 0};
        tbl[7]  = '{-1,  -1, 1'b0, 1'b0,    1,   0, 0, 0, 0, 0};
        tbl[8]  = '{798,  0, 1'b0, 1'b1,  799,   0, 0, 0, 0, 0};
        tbl[9]  = '{799,  0, 1'b0, 1'b1,  800,   0, 1, 0, 0, 0};
        tbl[10] = '{838,  0, 1'b0, 1'b1,  839,   0, 1, 0, 0, 0};
        tbl[11] = '{839,  0, 1'b0, 1'b1,  840,   0, 1, 1, 0, 0};
        tbl[12] = '{966,  0, 1'b0, 1'b1,  967,   0, 1, 1, 0, 0};
        tbl[13] = '{967,  0, 1'b0, 1'b1,  968,   0, 1, 0, 0, 0};
        tbl[14] = '{1055, 599, 1'b0, 1'b1,  0, 600, 0, 0, 1, 0};
        tbl[15] = '{1055, 600, 1'b0, 1'b1,  0, 601, 0, 0, 1, 1};
        tbl[16] = '{1054, 604, 1'b0, 1'b1, 1055, 604, 1, 0, 1, 1};
        tbl[17] = '{1055, 604, 1'b0, 1'b1,  0, 605, 0, 0, 1, 0};

        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        check_model("reset_state");
        chk("reset_hcount", int'(tim_if.hcount), 0);
        chk("reset_vcount", int'(tim_if.vcount), 0);

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].sh >= 0) seek(tbl[i].sh, tbl[i].sv);
            cyc(tbl[i].r, tbl[i].e);
            chk($sformatf("vec%0d_h", i),  int'(tim_if.hcount), tbl[i].h);
            chk($sformatf("vec%0d_v", i),  int'(tim_if.vcount), tbl[i].v);
            chk($sformatf("vec%0d_hb", i), int'(tim_if.hblnk),  int'(tbl[i].hb));
            chk($sformatf("vec%0d_hs", i), int'(tim_if.hsync),  int'(tbl[i].hs));
            chk($sformatf("vec%0d_vb", i), int'(tim_if.vblnk),  int'(tbl[i].vb));
            chk($sformatf("vec%0d_vs", i), int'(tim_if.vsync),  int'(tbl[i].vs));
        end

        // Randomized segments from random positions, checked every cycle.
        for (int s = 0; s < 8; s++) begin
            seek($urandom_range(700, H_TOT - 1), $urandom_range(0, V_TOT - 1));
            cyc(1'b0, 1'b1);
            for (int k = 0; k < 400; k++) begin
                cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0));
                check_model("random");
            end
        end

        // Mid-frame reset held 3 cycles.
        seek(499, 300);
        cyc(1'b0, 1'b1);
        chk("rst_pre_h", int'(tim_if.hcount), 500);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1);
            check_model("rst_hold");
            chk("rst_hold_h", int'(tim_if.hcount), 0);
            chk("rst_hold_v", int'(tim_if.vcount), 0);
        end
        cyc(1'b0, 1'b1);
        chk("rst_release_h", int'(tim_if.hcount), 1);
        chk("rst_release_v", int'(tim_if.vcount), 0);
`ifdef VGA_TIMING_SOF_EN
        chk("rst_no_sof", int'(sof), 0);
`endif

        // Line wrap.
        seek(1053, 10);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk("wrap_pre_h", int'(tim_if.hcount), 1055);
        chk("wrap_pre_hb", int'(tim_if.hblnk), 1);
        cyc(1'b0, 1'b1);
        chk("wrap_h", int'(tim_if.hcount), 0);
        chk("wrap_v", int'(tim_if.vcount), 11);
        chk("wrap_hb", int'(tim_if.hblnk), 0);

        // Full scan of line 5.
        seek(1055, 4);
        hs_cnt = 0; first_hb = -1; vb_seen = 0;
        for (int k = 0; k < H_TOT; k++) begin
            cyc(1'b0, 1'b1);
            check_model("line5");
            if (tim_if.hsync) hs_cnt++;
            if (tim_if.hblnk && first_hb < 0) first_hb = int'(tim_if.hcount);
            if (tim_if.vblnk) vb_seen++;
        end
        chk("line5_hsync_cycles", hs_cnt, 128);
        chk("line5_hblnk_rise", first_hb, 800);
        chk("line5_vblnk", vb_seen, 0);

        // Vertical blanking region through frame wrap.
        seek(1055, 597);
        vs_cnt = 0; vb_cnt = 0; first_vs_h = -1; first_vs_v = -1;
        for (int k = 0; k < 31 * H_TOT; k++) begin
            cyc(1'b0, 1'b1);
            check_model("vscan");
            if (tim_if.vsync) begin
                vs_cnt++;
                if (first_vs_h < 0) begin
                    first_vs_h = int'(tim_if.hcount);
                    first_vs_v = int'(tim_if.vcount);
                end
            end
            if (tim_if.vblnk) vb_cnt++;
        end
        chk("vsync_cycles", vs_cnt, 4 * H_TOT);
        chk("vblnk_cycles", vb_cnt, 28 * H_TOT);
        chk("vsync_rise_h", first_vs_h, 0);
        chk("vsync_rise_v", first_vs_v, 601);

        // Enable gating at the blanking edge.
        seek(798, 599);
        cyc(1'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            cyc(1'b0, 1'b0);
            check_model("en_hold");
        end
        chk("en_hold_h", int'(tim_if.hcount), 799);
        chk("en_hold_v", int'(tim_if.vcount), 599);
        chk("en_hold_hb", int'(tim_if.hblnk), 0);
        cyc(1'b0, 1'b1);
        chk("en_resume_h", int'(tim_if.hcount), 800);
        chk("en_resume_hb", int'(tim_if.hblnk), 1);

`ifdef VGA_TIMING_SOF_EN
        seek(1054, 627);
        cyc(1'b0, 1'b1);
        chk("sof_pre", int'(sof), 0);
        cyc(1'b0, 1'b1);
        chk("sof_wrap", int'(sof), 1);
        chk("sof_wrap_h", int'(tim_if.hcount), 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0);
            chk("sof_en_low", int'(sof), 0);
        end
        cyc(1'b0, 1'b1);
        chk("sof_after", int'(sof), 0);
        cyc(1'b1, 1'b1);
        chk("sof_in_rst", int'(sof), 0);
        cyc(1'b0, 1'b1);
        chk("sof_post_rst", int'(sof), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
